strobe_demux: RTL
=================

Name: strobe_demux

Overview:
- Parametrised, registered successor to the 3-to-8 active-low demux.
- Decodes a latched select address onto one of OUTPUTS active-low strobe lines.
- The strobe is timed: SETUP cycles of address settle, PULSE cycles low, then HOLD cycles before the next access.
- Sits between the sequencer and the device-select bus; it gives glitch-free, width-controlled chip-select/write strobes to downstream register and memory models.

Parameters:
- SEL_W, 3, width of select address.
- OUTPUTS, 8, number of strobe lines; legal range 2..2**SEL_W.
- SETUP, 1, cycles between accept and strobe assertion; 0 allowed.
- PULSE, 2, cycles strobe is held low; minimum 1.
- HOLD, 1, cycles after strobe release before done; 0 allowed.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  1  access request, sampled when busy=0.
- sel  in  SEL_W  target line index, sampled with req.
- busy  out  1  access in progress; req ignored while high.
- done  out  1  one-cycle pulse marking the end of an access.
- err  out  1  out-of-range select flag (see Optional Feature).
- out_n  out  OUTPUTS  active-low strobes; at most one bit low at any time.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset (asserted at any time, including mid-access):
  - out_n = all ones, busy=0, done=0, err=0, FSM=IDLE, counters=0.
  - The takes effect immediately, without waiting for a clock edge.
- All outputs are registered; no combinational path from req/sel to any output.
- FSM states: IDLE, SETUP, ACTIVE, HOLD.
- IDLE:
  - If req=1, latch sel into sel_q and set busy=1 on the next edge.
  - Next state is SETUP if SETUP>0, else ACTIVE.
  - If req=0, stay in IDLE.
- SETUP:
  - Count SETUP cycles, out_n all ones.
  - Then go to ACTIVE.
- ACTIVE:
  - out_n[sel_q]=0 for exactly PULSE cycles; all other bits stay 1.
  - Then go to HOLD if HOLD>0, else IDLE.
- HOLD:
  - out_n all ones for HOLD cycles.
  - Then go to IDLE.
- On the edge entering IDLE from an access: busy=0 and done=1 for one cycle.
- Back-to-back accesses:
  - A req present in that done cycle is accepted.
  - Access period = 1+SETUP+PULSE+HOLD cycles.
- Latency: with req accepted at edge k, out_n goes low at edge k+1+SETUP and returns high at edge k+1+SETUP+PULSE.
- Out-of-range select (sel_q >= OUTPUTS):
  - The FSM runs its full timing and done still pulses.
  - No out_n bit goes low.
- sel and req changes while busy=1 have no effect; sel_q is held.
- Counter width is clog2(max(SETUP,PULSE,HOLD)+1); each counter is cleared on every state entry.
- Reference point: with SEL_W=3, OUTPUTS=8, SETUP=0, PULSE=1, HOLD=0, the decoded pattern per access equals the legacy 3-to-8 table, e.g. sel=3 gives out_n 8'b1111_0111.

Optional Feature:
- Macro: STROBE_DEMUX_ERR_EN.
- Defined:
  - err is a sticky flag, set on the accept edge of any req with sel >= OUTPUTS.
  - err is cleared only by reset_n.
  - The out-of-range access is dropped: no FSM run, busy stays 0, done pulses one cycle later.
- Undefined:
  - err is tied 0.
  - Out-of-range accesses run the full timing with no strobe, as described in Behaviour.

Test Plan:
- Defaults, reset then req with sel=5 at edge 0 -> busy=1 at edge 1; out_n=8'b1101_1111 during edges 2-3; all ones at edge 4; done=1 at edge 5 with busy=0.
- Back-to-back: req held high with sel=1 then sel=6 -> second access accepted in the done cycle; period 5 cycles; out_n never has two bits low and never glitches between accesses.
- sel and req toggled every cycle while busy=1 -> strobe stays on the originally latched line; no extra accesses occur.
- reset_n pulsed low during ACTIVE (sel=2) -> out_n returns to 8'hFF and busy=0 with no clock edge; the next req starts a clean access.
- OUTPUTS=6, sel=7:
  - Macro undefined: 5-cycle access, no strobe, err=0.
  - STROBE_DEMUX_ERR_EN defined: err=1 until reset, busy never rises, done pulses next cycle.
- SETUP=0, PULSE=1, HOLD=0, sweep sel 0..7 -> single-cycle low on out_n[sel] matching the legacy active-low table; period 2 cycles.

Source files
------------

// File: rtl/strobe_demux.sv
// ---------------------------------------------------------------------------
// strobe_demux
//
// Purpose:
//   Registered, timed successor to the 3-to-8 active-low demux. A request
//   latches a select address, waits SETUP cycles for the address to settle,
//   drives out_n[sel] low for PULSE cycles, then waits HOLD cycles before the
//   access completes. The result is glitch-free, width-controlled chip-select
//   and write strobes for the device-select bus.
//
// Ports:
//   clk      in   1        system clock, rising edge
//   reset_n  in   1        asynchronous active-low reset
//   req      in   1        access request, sampled only while idle
//   sel      in   SEL_W    target strobe index, sampled with req
//   busy     out  1        access in progress; req ignored while high
//   done     out  1        one-cycle pulse marking the end of an access
//   err      out  1        sticky out-of-range flag (optional feature)
//   out_n    out  OUTPUTS  active-low strobes, at most one low at a time
//
// Optional feature (macro STROBE_DEMUX_ERR_EN):
//   Defined   : a request with sel >= OUTPUTS sets the sticky err flag, is
//               dropped without running the timing, and done pulses on the
//               following cycle.
//   Undefined : err is tied low; out-of-range accesses run the full timing
//               without asserting any strobe.
// ---------------------------------------------------------------------------
module strobe_demux #(
    parameter int SEL_W   = 3,
    parameter int OUTPUTS = 8,
    parameter int SETUP   = 1,
    parameter int PULSE   = 2,
    parameter int HOLD    = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req,
    input  logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [OUTPUTS-1:0] out_n
);

    localparam int MAX_T = (SETUP > PULSE) ? ((SETUP > HOLD) ? SETUP : HOLD)
                                           : ((PULSE > HOLD) ? PULSE : HOLD);
    localparam int CNT_W = $clog2(MAX_T + 1);

    // Terminal counts; a phase whose length is zero is never entered, so its
    // terminal value is irrelevant and clamped to zero.
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'((SETUP > 0) ? SETUP - 1 : 0);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((HOLD > 0) ? HOLD - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [OUTPUTS-1:0] out_n_q, out_n_d;

`ifdef STROBE_DEMUX_ERR_EN
    logic sel_in_range_s;
    // OUTPUTS may equal 2**SEL_W, so compare one bit wider than sel.
    assign sel_in_range_s = ({1'b0, sel} < (SEL_W + 1)'(OUTPUTS));
`endif

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
`ifdef STROBE_DEMUX_ERR_EN
        err_d   = err_q;
`else
        err_d   = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req) begin
`ifdef STROBE_DEMUX_ERR_EN
                    if (!sel_in_range_s) begin
                        // Dropped access: flag it and finish immediately.
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        sel_d   = sel;
                        cnt_d   = '0;
                        state_d = (SETUP > 0) ? ST_SETUP : ST_ACTIVE;
                    end
`else
                    sel_d   = sel;
                    cnt_d   = '0;
                    state_d = (SETUP > 0) ? ST_SETUP : ST_ACTIVE;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d = '0;
                    if (HOLD > 0) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);

        // Decode from the next state and next select so the strobe register
        // changes on the same edge as the state, with no combinational output.
        // An out-of-range select matches no index and leaves every line high.
        for (int i = 0; i < OUTPUTS; i++) begin
            out_n_d[i] = !((state_d == ST_ACTIVE) && (sel_d == SEL_W'(i)));
        end
    end

    // State, counter, latched select and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            out_n_q <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            out_n_q <= out_n_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign out_n = out_n_q;

endmodule
